// File: rtl/dmem_responder.sv
// Wait-state data memory for the M stage: accepts one load/store, holds the pipeline through WAIT_CYCLES,
// then pulses resp_valid (latency WAIT_CYCLES+1). stall_M is the only backpressure; no request queueing.
module dmem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        stall_M,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT   = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, nextState;
    logic [3:0]  waitCnt;
    logic        latWe;
    logic [31:0] latAddr;
    logic [31:0] latWdata;
    logic [3:0]  latBe;
    logic [31:0] mem [DEPTH_WORDS];

    logic             accWe;
    logic [31:0]      accAddr;
    logic [31:0]      accWdata;
    logic [3:0]       accBe;
    logic [31:0]      accOff;
    logic             accErr;
    logic [IDX_W-1:0] accIdx;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState  = state;
        req_ready  = 1'b0;
        stall_M    = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = req_valid;
                stall_M   = req_valid;
                if (req_valid) nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                stall_M = 1'b1;
                if (waitCnt <= 4'd1) nextState = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge, so the request
    // fields are taken straight from the port (they are what gets latched that edge).
    always_comb begin
        accWe    = (state == IDLE) ? req_we    : latWe;
        accAddr  = (state == IDLE) ? req_addr  : latAddr;
        accWdata = (state == IDLE) ? req_wdata : latWdata;
        accBe    = (state == IDLE) ? req_be    : latBe;
        accOff   = accAddr - ADDR_BASE;
        accErr   = (accAddr[1:0] != 2'b00) || (accOff >= SPAN_BYTES);
        accIdx   = accOff[IDX_W+1:2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt    <= '0;
            latWe      <= 1'b0;
            latAddr    <= '0;
            latWdata   <= '0;
            latBe      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                latWe    <= req_we;
                latAddr  <= req_addr;
                latWdata <= req_wdata;
                latBe    <= req_be;
                waitCnt  <= CNT_INIT;
            end else if (state == WAIT) begin
                waitCnt <= waitCnt - 4'd1;
            end

            // Response fields update only on the edge entering RESP and hold otherwise.
            if (nextState == RESP && state != RESP) begin
                resp_err   <= accErr;
                resp_rdata <= (accErr || accWe) ? 32'h0 : mem[accIdx];
                if (accWe && !accErr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (accBe[b]) mem[accIdx][8*b +: 8] <= accWdata[8*b +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance A uses two wait states, instance B zero wait states.
module tb_dmem_responder;
    logic        clk;
    logic        reset;

    logic        aValid, aWe;
    logic [31:0] aAddr, aWdata;
    logic [3:0]  aBe;
    logic        aReady, aStall, aRespValid, aErr;
    logic [31:0] aRdata;

    logic        bValid, bWe;
    logic [31:0] bAddr, bWdata;
    logic [3:0]  bBe;
    logic        bReady, bStall, bRespValid, bErr;
    logic [31:0] bRdata;

    int tests = 0;
    int fails = 0;

    dmem_responder #(.ADDR_BASE(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dutA (
        .clk(clk), .reset(reset),
        .req_valid(aValid), .req_we(aWe), .req_addr(aAddr), .req_wdata(aWdata), .req_be(aBe),
        .req_ready(aReady), .stall_M(aStall), .resp_valid(aRespValid),
        .resp_rdata(aRdata), .resp_err(aErr)
    );

    dmem_responder #(.ADDR_BASE(32'h0), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) dutB (
        .clk(clk), .reset(reset),
        .req_valid(bValid), .req_we(bWe), .req_addr(bAddr), .req_wdata(bWdata), .req_be(bBe),
        .req_ready(bReady), .stall_M(bStall), .resp_valid(bRespValid),
        .resp_rdata(bRdata), .resp_err(bErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request on the chosen instance; returns cycles from accept to resp_valid (-1 on timeout).
    task automatic doReq(input bit useB, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output int lat, output logic [31:0] rd, output logic er);
        lat = -1;
        rd  = 'x;
        er  = 'x;
        @(negedge clk);
        if (useB) begin
            bValid = 1'b1; bWe = we; bAddr = addr; bWdata = wdata; bBe = be;
        end else begin
            aValid = 1'b1; aWe = we; aAddr = addr; aWdata = wdata; aBe = be;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (useB ? bRespValid : aRespValid) begin
                lat = i;
                rd  = useB ? bRdata : aRdata;
                er  = useB ? bErr : aErr;
                break;
            end
            @(negedge clk);
        end
        aValid = 1'b0;
        bValid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++; if (aStall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", aStall); end
        tests++; if (aReady !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", aReady); end
        tests++; if (aRespValid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b want 0", aRespValid); end
        tests++; if (aRdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", aRdata); end
        tests++; if (aErr !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", aErr); end
        tests++; if (bRespValid !== 1'b0 || bRdata !== 32'h0) begin
            fails++; $display("FAIL reset_b: got valid=%b rdata=%h want 0/0", bRespValid, bRdata);
        end
    endtask

    task automatic test_store_load;
        int lat;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        aValid = 1'b1; aWe = 1'b1; aAddr = 32'h10; aWdata = 32'hDEADBEEF; aBe = 4'hF;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++; if (aStall !== (c < 3)) begin fails++; $display("FAIL store_stall c%0d: got %b want %b", c, aStall, c < 3); end
            tests++; if (aRespValid !== (c == 3)) begin fails++; $display("FAIL store_resp c%0d: got %b want %b", c, aRespValid, c == 3); end
            if (c == 0) begin
                tests++; if (aReady !== 1'b1) begin fails++; $display("FAIL store_ready: got %b want 1", aReady); end
            end
            if (c == 3) begin
                tests++; if (aErr !== 1'b0 || aRdata !== 32'h0) begin
                    fails++; $display("FAIL store_resp_fields: got err=%b rdata=%h want 0/0", aErr, aRdata);
                end
            end
            if (c < 3) @(negedge clk);
        end
        aValid = 1'b0;
        doReq(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        tests++; if (lat !== 3) begin fails++; $display("FAIL load_latency: got %0d want 3", lat); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL load_data: got %h want deadbeef", rd); end
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL load_err: got %b want 0", er); end
    endtask

    task automatic test_byte_enable;
        int lat;
        logic [31:0] rd;
        logic er;
        doReq(1'b0, 1'b1, 32'h18, 32'hAABBCCDD, 4'hF, lat, rd, er);
        doReq(1'b0, 1'b1, 32'h18, 32'h11223344, 4'b0101, lat, rd, er);
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL be_store_err: got %b want 0", er); end
        doReq(1'b0, 1'b0, 32'h18, 32'h0, 4'h0, lat, rd, er);
        tests++; if (rd !== 32'hAA22CC44) begin fails++; $display("FAIL be_merge: got %h want aa22cc44", rd); end
        doReq(1'b0, 1'b1, 32'h18, 32'h0, 4'h0, lat, rd, er);
        tests++; if (lat !== 3 || er !== 1'b0) begin fails++; $display("FAIL be_zero_store: got lat=%0d err=%b want 3/0", lat, er); end
        doReq(1'b0, 1'b0, 32'h18, 32'h0, 4'h0, lat, rd, er);
        tests++; if (rd !== 32'hAA22CC44) begin fails++; $display("FAIL be_zero_nochange: got %h want aa22cc44", rd); end
    endtask

    task automatic test_errors;
        int lat;
        logic [31:0] rd;
        logic er;
        doReq(1'b0, 1'b1, 32'h0, 32'h12345678, 4'hF, lat, rd, er);
        doReq(1'b0, 1'b0, 32'h12, 32'h0, 4'h0, lat, rd, er);
        tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL misaligned_load: got err=%b rdata=%h want 1/0", er, rd); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL err_latency: got %0d want 3", lat); end
        @(negedge clk);
        #1;
        tests++; if (aRespValid !== 1'b0 || aErr !== 1'b1 || aRdata !== 32'h0) begin
            fails++; $display("FAIL err_hold: got valid=%b err=%b rdata=%h want 0/1/0", aRespValid, aErr, aRdata);
        end
        doReq(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, lat, rd, er);
        tests++; if (er !== 1'b1 || lat !== 3) begin fails++; $display("FAIL oor_store: got err=%b lat=%0d want 1/3", er, lat); end
        doReq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
        tests++; if (rd !== 32'h12345678 || er !== 1'b0) begin fails++; $display("FAIL oor_word0: got %h err=%b want 12345678/0", rd, er); end
        doReq(1'b0, 1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, lat, rd, er);
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL last_word_store: got err=%b want 0", er); end
        doReq(1'b0, 1'b0, 32'hFFC, 32'h0, 4'h0, lat, rd, er);
        tests++; if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL last_word_load: got %h want 0badf00d", rd); end
        doReq(1'b0, 1'b0, 32'h11, 32'h0, 4'h0, lat, rd, er);
        tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL misaligned_1: got err=%b rdata=%h want 1/0", er, rd); end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [31:0] rd;
        logic er;
        doReq(1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, lat, rd, er);
        tests++; if (lat !== 1) begin fails++; $display("FAIL w0_latency: got %0d want 1", lat); end
        @(negedge clk);
        bValid = 1'b1; bWe = 1'b0; bAddr = 32'h8; bWdata = 32'h0; bBe = 4'h0;
        for (int c = 0; c < 6; c++) begin
            #1;
            tests++; if (bStall !== (c % 2 == 0)) begin fails++; $display("FAIL b2b_stall c%0d: got %b want %b", c, bStall, c % 2 == 0); end
            tests++; if (bRespValid !== (c % 2 == 1)) begin fails++; $display("FAIL b2b_resp c%0d: got %b want %b", c, bRespValid, c % 2 == 1); end
            if (c % 2 == 1) begin
                tests++; if (bRdata !== 32'hCAFEF00D) begin fails++; $display("FAIL b2b_data c%0d: got %h want cafef00d", c, bRdata); end
            end
            @(negedge clk);
        end
        bValid = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [31:0] rd;
        logic er;
        bit sawResp;
        @(negedge clk);
        aValid = 1'b1; aWe = 1'b1; aAddr = 32'h20; aWdata = 32'h55; aBe = 4'hF;
        @(negedge clk);
        #1;
        tests++; if (aStall !== 1'b1) begin fails++; $display("FAIL mid_in_wait: got stall=%b want 1", aStall); end
        reset  = 1'b1;
        aValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++; if (aStall !== 1'b0 || aRespValid !== 1'b0) begin
            fails++; $display("FAIL mid_idle: got stall=%b valid=%b want 0/0", aStall, aRespValid);
        end
        sawResp = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (aRespValid) sawResp = 1'b1;
        end
        tests++; if (sawResp !== 1'b0) begin fails++; $display("FAIL mid_no_resp: got %b want 0", sawResp); end
        doReq(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
        tests++; if (rd !== 32'h0 || lat !== 3) begin fails++; $display("FAIL mid_not_written: got %h lat=%0d want 0/3", rd, lat); end
    endtask

    task automatic test_idle;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            tests++; if (aStall !== 1'b0 || aReady !== 1'b0 || aRespValid !== 1'b0) begin
                fails++; $display("FAIL idle_a c%0d: got stall=%b ready=%b valid=%b want 0/0/0", c, aStall, aReady, aRespValid);
            end
            tests++; if (bStall !== 1'b0 || bReady !== 1'b0 || bRespValid !== 1'b0) begin
                fails++; $display("FAIL idle_b c%0d: got stall=%b ready=%b valid=%b want 0/0/0", c, bStall, bReady, bRespValid);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        aValid = 1'b0; aWe = 1'b0; aAddr = '0; aWdata = '0; aBe = '0;
        bValid = 1'b0; bWe = 1'b0; bAddr = '0; bWdata = '0; bBe = '0;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
